itf_cmd_arbiter: RTL
====================

// Module: itf_cmd_arbiter
// PURPOSE
//  Shares the single off-chip 128-bit data port among NUM_REQ on-chip modules (FPS/KNN/SYA/POL/GIC/MON).
//  Round-robin grants one requester at a time and emits its command word to the off-chip host.
//  Steers the data beats of the granted transfer (DRAM->chip or chip->DRAM) to or from that requester.
//  Sits between the module DMA ports and the pad/async-FIFO interface logic.
// PARAMETERS
//  NUM_REQ          6    number of requesters
//  PORT_WIDTH       128  off-chip data beat width (bits)
//  DRAM_ADDR_WIDTH  32   DRAM word address width
//  ADDR_WIDTH       16   transfer length field width, in 256-bit words
// PORTS
//  clk        in   1                        core clock, single clock domain
//  rst        in   1                        asynchronous, active-high reset
//  req_vld    in   NUM_REQ                  per-requester command request
//  req_rdy    out  NUM_REQ                  one-hot command accept pulse
//  req_wr     in   NUM_REQ                  1 = chip->DRAM, 0 = DRAM->chip
//  req_addr   in   NUM_REQ*DRAM_ADDR_WIDTH  DRAM start address
//  req_num    in   NUM_REQ*ADDR_WIDTH       length in 256-bit words
//  cmd_vld    out  1                        command word valid to host
//  cmd_rdy    in   1                        host accepts command
//  cmd_dat    out  PORT_WIDTH               {0, num[15:0], addr[31:0], wr}; bit0 = wr
//  in_vld, in_dat[PORT_WIDTH], in_last  in   read beats from host
//  in_rdy     out  1                        read beat accept
//  rdat_vld   out  NUM_REQ                  read beat valid; one-hot, granted requester only
//  rdat       out  PORT_WIDTH               shared read data = in_dat
//  rdat_rdy   in   NUM_REQ                  requester read accept
//  wdat_vld   in   NUM_REQ                  write beat valid
//  wdat       in   NUM_REQ*PORT_WIDTH       write data
//  wdat_rdy   out  NUM_REQ                  one-hot write accept
//  out_vld, out_dat[PORT_WIDTH], out_last  out  write beats to host
//  out_rdy    in   1                        host accepts write beat
//  busy       out  1                        state != IDLE
//  gnt_idx    out  clog2(NUM_REQ)           current or last grant
//  err        out  1                        sticky: in_last disagrees with beat count
// BEHAVIOUR
//  Reset: state IDLE, rr ptr=0. Outputs req_rdy, cmd_vld, in_rdy, rdat_vld, wdat_rdy, out_vld, out_last,
//   busy, gnt_idx and err are all 0. Reset mid-transfer aborts the transfer with no completion pulse.
//  FSM IDLE -> CMD -> XFER_RD | XFER_WR -> IDLE.
//  IDLE: if |req_vld, grant the first set bit at or after ptr, wrapping at NUM_REQ.
//   In the same cycle: req_rdy[g]=1, latch wr/addr/num, gnt_idx<=g, ptr<=(g+1)%NUM_REQ.
//   If num==0: accept and drop, stay in IDLE, issue no command.
//  CMD: cmd_vld=1 from the cycle after the grant; cmd_dat stays stable until cmd_rdy.
//   On cmd_rdy: clear beat cnt; go to XFER_WR if wr=1, else XFER_RD.
//  Beats: total = 2*num, computed at ADDR_WIDTH+1 bits; num=0xFFFF gives 131070 beats.
//   cnt increments on each beat handshake; the last beat is cnt==total-1.
//  XFER_RD: in_rdy=rdat_rdy[g]; rdat_vld[g]=in_vld; rdat=in_dat. Pass-through is combinational, 0 latency.
//   If in_last != (cnt==total-1) on a handshake, set err.
//  XFER_WR: out_vld=wdat_vld[g]; out_dat=wdat[g]; wdat_rdy[g]=out_rdy; out_last=(cnt==total-1).
//  Both XFER states return to IDLE the cycle after the last-beat handshake, so a new grant is earliest
//   one cycle later. Non-granted lanes get rdy/vld=0.
//  Requests arriving during a transfer wait; req_vld must hold until req_rdy.
//  err clears only on rst.
// STRUCTURE
//  itf_pkg: state enum, CMD_WR_BIT=0, CMD_ADDR_LSB=1, CMD_NUM_LSB=33, beat-count width.
//  Sub-module rr_arbiter (NUM_REQ): req, ptr -> one-hot gnt + index. The rest is the FSM plus muxes.
// TESTING
//  1. Single read: req 2 rd addr=0x100 num=3 -> cmd_dat[48:0]={3,0x100,0}; 6 beats to rdat_vld[2]; err=0.
//  2. Single write: req 5 num=1 -> 2 beats; out_last on beat 2 only; busy falls one cycle later.
//  3. All 6 requesting, ptr=0 -> grant order 0,1,2,3,4,5,0; no requester starves.
//  4. Backpressure: toggle cmd_rdy, out_rdy and rdat_rdy randomly -> cmd_dat stable; beats neither lost nor duplicated.
//  5. num=0 on req 1 -> req_rdy[1] pulse, cmd_vld stays 0, ptr=2. in_last on beat 3 of 6 -> err=1.
//  6. rst asserted mid-XFER_RD at beat 4 -> next cycle all outputs 0, state IDLE, ptr=0.

Source files
------------

// File: rtl/itf_cmd_arbiter_pkg.sv
// Shared types and field positions for the off-chip command/data port arbiter.
package itf_cmd_arbiter_pkg;

    localparam int NUM_REQ_DEF         = 6;
    localparam int PORT_WIDTH_DEF      = 128;
    localparam int DRAM_ADDR_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF      = 16;

    localparam int CMD_WR_BIT   = 0;
    localparam int CMD_ADDR_LSB = 1;
    localparam int CMD_NUM_LSB  = 33;

    // One 256-bit word is two port beats, so the beat count needs one extra bit.
    localparam int BEAT_CNT_W = ADDR_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_XFER_RD = 2'd2,
        ST_XFER_WR = 2'd3
    } state_t;

endpackage

// File: rtl/itf_cmd_arbiter_if.sv
// Bundle of requester, host command, and data beat signals around the arbiter.
interface itf_cmd_arbiter_if #(
    parameter int NUM_REQ         = 6,
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int GNT_W           = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                 req_vld;
    logic [NUM_REQ-1:0]                 req_rdy;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*ADDR_WIDTH-1:0]      req_num;

    logic                               cmd_vld;
    logic                               cmd_rdy;
    logic [PORT_WIDTH-1:0]              cmd_dat;

    logic                               in_vld;
    logic [PORT_WIDTH-1:0]              in_dat;
    logic                               in_last;
    logic                               in_rdy;

    logic [NUM_REQ-1:0]                 rdat_vld;
    logic [PORT_WIDTH-1:0]              rdat;
    logic [NUM_REQ-1:0]                 rdat_rdy;

    logic [NUM_REQ-1:0]                 wdat_vld;
    logic [NUM_REQ*PORT_WIDTH-1:0]      wdat;
    logic [NUM_REQ-1:0]                 wdat_rdy;

    logic                               out_vld;
    logic [PORT_WIDTH-1:0]              out_dat;
    logic                               out_last;
    logic                               out_rdy;

    logic                               busy;
    logic [GNT_W-1:0]                   gnt_idx;
    logic                               err;

    modport slave (
        input  req_vld, req_wr, req_addr, req_num,
        output req_rdy,
        output cmd_vld, cmd_dat,
        input  cmd_rdy,
        input  in_vld, in_dat, in_last,
        output in_rdy,
        output rdat_vld, rdat,
        input  rdat_rdy,
        input  wdat_vld, wdat,
        output wdat_rdy,
        output out_vld, out_dat, out_last,
        input  out_rdy,
        output busy, gnt_idx, err
    );

    modport master (
        output req_vld, req_wr, req_addr, req_num,
        input  req_rdy,
        input  cmd_vld, cmd_dat,
        output cmd_rdy,
        output in_vld, in_dat, in_last,
        input  in_rdy,
        input  rdat_vld, rdat,
        output rdat_rdy,
        output wdat_vld, wdat,
        input  wdat_rdy,
        input  out_vld, out_dat, out_last,
        output out_rdy,
        input  busy, gnt_idx, err
    );

endinterface

// File: rtl/itf_cmd_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping at NUM_REQ.
module itf_cmd_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int unsigned w_pos;
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/itf_cmd_arbiter.sv
// Grants one requester at a time to the off-chip port, issues its command word,
// then steers its read or write beats until the transfer length is exhausted.
module itf_cmd_arbiter
    import itf_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEF,
    parameter int PORT_WIDTH      = PORT_WIDTH_DEF,
    parameter int DRAM_ADDR_WIDTH = DRAM_ADDR_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    itf_cmd_arbiter_if.slave   bus
);

    // state      | meaning
    // ST_IDLE    | waiting for a request; grant and latch happen here
    // ST_CMD     | command word presented to host until cmd_rdy
    // ST_XFER_RD | host read beats passed through to the granted requester
    // ST_XFER_WR | granted requester write beats passed through to host

    localparam int GNT_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = ADDR_WIDTH + 1;

    state_t                       r_state;
    state_t                       w_next;
    logic [GNT_W-1:0]             r_ptr;
    logic [GNT_W-1:0]             r_gnt;
    logic                         r_wr;
    logic [DRAM_ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]        r_num;
    logic [BEAT_W-1:0]            r_cnt;
    logic                         r_err;

    logic [NUM_REQ-1:0]           w_req_gnt;
    logic [GNT_W-1:0]             w_req_idx;
    logic                         w_req_any;
    logic [ADDR_WIDTH-1:0]        w_num_sel;
    logic [BEAT_W-1:0]            w_total;
    logic                         w_last;
    logic                         w_accept;
    logic                         w_cmd_hs;
    logic                         w_beat_hs;
    logic [NUM_REQ-1:0]           w_req_rdy;
    logic                         w_cmd_vld;
    logic [PORT_WIDTH-1:0]        w_cmd_dat;
    logic                         w_in_rdy;
    logic [NUM_REQ-1:0]           w_rdat_vld;
    logic [NUM_REQ-1:0]           w_wdat_rdy;
    logic                         w_out_vld;
    logic                         w_out_last;

    itf_cmd_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GNT_W)
    ) u_rr (
        .i_req (bus.req_vld),
        .i_ptr (r_ptr),
        .o_gnt (w_req_gnt),
        .o_idx (w_req_idx),
        .o_any (w_req_any)
    );

    assign w_num_sel = bus.req_num[int'(w_req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_total   = {r_num, 1'b0};
    assign w_last    = (r_cnt == w_total - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_cmd_hs   = 1'b0;
        w_beat_hs  = 1'b0;
        w_req_rdy  = '0;
        w_cmd_vld  = 1'b0;
        w_in_rdy   = 1'b0;
        w_rdat_vld = '0;
        w_wdat_rdy = '0;
        w_out_vld  = 1'b0;
        w_out_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_accept  = 1'b1;
                    w_req_rdy = w_req_gnt;
                    // Zero-length requests are acknowledged and dropped without a command.
                    if (w_num_sel != '0) begin
                        w_next = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                w_cmd_vld = 1'b1;
                if (bus.cmd_rdy) begin
                    w_cmd_hs = 1'b1;
                    w_next   = r_wr ? ST_XFER_WR : ST_XFER_RD;
                end
            end
            ST_XFER_RD: begin
                w_in_rdy          = bus.rdat_rdy[r_gnt];
                w_rdat_vld[r_gnt] = bus.in_vld;
                w_beat_hs         = bus.in_vld & bus.rdat_rdy[r_gnt];
                if (w_beat_hs && w_last) begin
                    w_next = ST_IDLE;
                end
            end
            ST_XFER_WR: begin
                w_out_vld         = bus.wdat_vld[r_gnt];
                w_wdat_rdy[r_gnt] = bus.out_rdy;
                w_out_last        = w_last;
                w_beat_hs         = bus.wdat_vld[r_gnt] & bus.out_rdy;
                if (w_beat_hs && w_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_num  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt  <= w_req_idx;
                r_ptr  <= (w_req_idx == GNT_W'(NUM_REQ - 1)) ? '0 : w_req_idx + 1'b1;
                r_wr   <= bus.req_wr[w_req_idx];
                r_addr <= bus.req_addr[int'(w_req_idx)*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
                r_num  <= w_num_sel;
            end
            if (w_cmd_hs) begin
                r_cnt <= '0;
            end else if (w_beat_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_beat_hs && (r_state == ST_XFER_RD) && (bus.in_last != w_last)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_cmd_dat                                  = '0;
        w_cmd_dat[CMD_WR_BIT]                      = r_wr;
        w_cmd_dat[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH] = r_addr;
        w_cmd_dat[CMD_NUM_LSB +: ADDR_WIDTH]       = r_num;
    end

    assign bus.req_rdy  = w_req_rdy;
    assign bus.cmd_vld  = w_cmd_vld;
    assign bus.cmd_dat  = w_cmd_dat;
    assign bus.in_rdy   = w_in_rdy;
    assign bus.rdat_vld = w_rdat_vld;
    assign bus.rdat     = bus.in_dat;
    assign bus.wdat_rdy = w_wdat_rdy;
    assign bus.out_vld  = w_out_vld;
    assign bus.out_dat  = bus.wdat[int'(r_gnt)*PORT_WIDTH +: PORT_WIDTH];
    assign bus.out_last = w_out_last;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.gnt_idx  = r_gnt;
    assign bus.err      = r_err;

endmodule
